// File: rtl/multicycle_alu_arbiter.sv
// multicycle_alu_arbiter: round-robin sharing of one start/done multi-cycle ALU among NUM_REQ requesters
module multicycle_alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDW     = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [4*NUM_REQ-1:0]  req_opcode,
   output logic [NUM_REQ-1:0]    resp_done,
   output logic [31:0]           resp_y,
   output logic                  resp_err,
   output logic                  busy,
   output logic [IDW-1:0]        owner,
   output logic                  alu_start,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [3:0]            alu_opcode,
   input  logic                  alu_done,
   input  logic [31:0]           alu_y
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] rr_q, rr_d, owner_q, owner_d, sel;
   logic [15:0] cnt_q, cnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [31:0] y_q, y_d, a_q, a_d, b_q, b_d;
   logic [3:0] op_q, op_d;
   logic err_q, err_d, busy_q, busy_d, start_q, start_d, found;
   // Search downward so the requester closest to rr wins.
   always_comb begin
      found = 1'b0;
      sel = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
            found = 1'b1;
            sel = IDW'((int'(rr_q) + k) % NUM_REQ);
         end
      end
   end
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      done_d  = '0;
      y_d     = y_q;
      err_d   = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      start_d = 1'b0;
      case (state_q)
         IDLE: if (found) begin
            owner_d = sel;
            a_d  = req_a[32*sel +: 32];
            b_d  = req_b[32*sel +: 32];
            op_d = req_opcode[4*sel +: 4];
            if (req_opcode[4*sel+3]) begin
               state_d = RESP;
               y_d     = '0;
               err_d   = 1'b1;
               done_d  = NUM_REQ'(1) << sel;
            end else begin
               state_d = ISSUE;
               start_d = 1'b1;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 16'd1;
            if (alu_done) begin
               y_d     = alu_y;
               done_d  = NUM_REQ'(1) << owner_q;
               state_d = RESP;
            end else if (TIMEOUT != 0 && cnt_q == 16'(TIMEOUT - 1)) begin
               y_d     = '0;
               err_d   = 1'b1;
               done_d  = NUM_REQ'(1) << owner_q;
               state_d = RESP;
            end
         end
         default: begin
            rr_d    = IDW'((int'(owner_q) + 1) % NUM_REQ);
            state_d = IDLE;
         end
      endcase
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         done_q  <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         y_q     <= y_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         start_q <= start_d;
         busy_q  <= busy_d;
      end
   end
   assign resp_done  = done_q;
   assign resp_y     = y_q;
   assign resp_err   = err_q;
   assign busy       = busy_q;
   assign owner      = owner_q;
   assign alu_start  = start_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_opcode = op_q;
endmodule

// File: doc/multicycle_alu_arbiter.md
Name: multicycle_alu_arbiter

Overview:
Shares one multi-cycle ALU (mult/div/mod unit with a start/done handshake) between NUM_REQ requesters, for example the CPU EX stage and a DMA/coprocessor path. Round-robin arbitration grants one requester at a time and latches its operands. It issues a one-cycle start to the ALU, waits for done, and routes the result back to the owner. It guards against invalid opcodes and a hung ALU with an error response.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IDW, 1, owner index width, equal to ceil(log2(NUM_REQ)) and at least 1
TIMEOUT, 1024, max cycles in WAIT before forced error response; 0 disables; must be at most 65535

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  level request per requester; held with stable operands until that requester's resp_done
req_a  in  32*NUM_REQ  operand A; requester i uses bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand B, same packing
req_opcode  in  4*NUM_REQ  ALU opcode, packing [4i+3:4i]; valid range 0..7
resp_done  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner
resp_y  out  32  result; valid while resp_done is high, held until next completion
resp_err  out  1  high with resp_done on invalid opcode or timeout
busy  out  1  high in every state except IDLE
owner  out  IDW  index of the current or last granted requester
alu_start  out  1  one-cycle start pulse to the ALU
alu_a  out  32  latched operand A to the ALU
alu_b  out  32  latched operand B to the ALU
alu_opcode  out  4  latched opcode to the ALU
alu_done  in  1  ALU completion pulse
alu_y  in  32  ALU result, sampled when alu_done is high

Behaviour:
- All outputs are registered. Reset (sampled at posedge while reset is 0) has these effects:
  - state goes to IDLE and the round-robin pointer rr goes to 0.
  - resp_done, resp_y, resp_err, busy, owner, alu_start, alu_a, alu_b, alu_opcode and the timeout counter all go to 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Pick the first i with req_valid[i]=1, searching rr, rr+1, … mod NUM_REQ.
  - If found: owner<=i; alu_a/alu_b/alu_opcode<=that requester's slice.
  - If opcode[3]=1 (invalid): go to RESP with resp_y<=0 and resp_err flagged. The ALU is never started.
  - Otherwise go to ISSUE. alu_start<=1, so it is visible during the ISSUE cycle.
  - If no request is found, stay in IDLE.
- ISSUE:
  - alu_start is high for exactly this cycle and is cleared by the next edge.
  - Counter <= 0. Go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - If alu_done=1: resp_y<=alu_y, err=0, go to RESP.
  - Else if TIMEOUT≠0 and counter==TIMEOUT-1: resp_y<=0, err=1, go to RESP.
  - alu_done has priority when both conditions hit in the same cycle.
- RESP:
  - resp_done[owner]=1 and resp_err=err for exactly this cycle.
  - rr<=(owner+1) mod NUM_REQ; go to IDLE.
  - The requester samples done and drops req_valid at the same edge, so IDLE never re-grants a finished request.
- Latency: with valid opcode and ALU latency L (cycles from start-visible to done-visible), resp_done rises L+3 cycles after req_valid is first sampled in IDLE. An invalid opcode completes in 2 cycles.
- alu_done seen outside WAIT (stray, or late after a timeout) is ignored.
- Operands are captured only at grant. Changes on req_* after grant have no effect.
- A requester that drops req_valid before completion still receives its resp_done pulse; the result is discarded by protocol.
- Reset mid-operation aborts everything immediately. The ALU is assumed to be reset by the same system reset.

Test Plan:
- Single request: req0 MULTU (op 1) a=6 b=7, ALU model with L=4 -> one alu_start pulse, resp_done=2'b01 after 7 cycles, resp_y=42, resp_err=0, busy falls after RESP.
- Contention: req0 and req1 both held high from reset, each re-asserting after done -> grants alternate 0,1,0,1; owner matches each pulse; resp_y carries each requester's own operands (DIVU 100/7=14 for req0, MODU 100%7=2 for req1).
- Invalid opcode: req1 op 4'b1000 -> alu_start never asserted, resp_done=2'b10 two cycles after grant, resp_y=0, resp_err=1.
- Timeout: TIMEOUT=16, ALU model never asserts done -> resp_done[owner] at 16 WAIT cycles, resp_y=0, resp_err=1. A late alu_done afterwards is ignored, and the next request is served normally.
- Reset in WAIT: assert reset mid-division -> next cycle all outputs are 0, state is IDLE, rr=0; a stray alu_done does not produce resp_done.
- Operand stability: change req_a the cycle after grant -> result uses the originally latched value.
